// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22/45 MDIO master.
//   mdio_state_e : frame sequencer states
//   ST_*/OP_*    : start and opcode field values
//   FRM_*        : bit offsets of the fields inside a 32-bit frame
//   mdio_frame() : assembles a frame with ST=01 and write turnaround (10)
package mdio_pkg;

  typedef enum logic [2:0] {
    GAP,
    IDLE,
    PRE,
    HDR,
    TA,
    DATA
  } mdio_state_e;

  localparam logic [1:0] ST_C22   = 2'b01;
  localparam logic [1:0] ST_C45   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int unsigned FRM_ST_LSB  = 30;
  localparam int unsigned FRM_OP_MSB  = 29;
  localparam int unsigned HDR_BITS    = 14;
  localparam int unsigned TA_BITS     = 2;
  localparam int unsigned DATA_BITS   = 16;

  function automatic logic [31:0] mdio_frame(input logic [1:0]  op,
                                             input logic [4:0]  phy,
                                             input logic [4:0]  regad,
                                             input logic [15:0] data);
    return {ST_C22, op, phy, regad, TA_WRITE, data};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: divides clk by 2*CLK_DIV.
//   clk, reset (async, active-low) : clock and reset; reset holds mdc low
//   mdc                            : management clock
//   rise_tick / fall_tick          : one-clk strobes on the clk where mdc toggles
module mdio_clk_gen #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic mdc,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic          mdc_q;
  logic          term;

  assign term      = (div_q == DW'(CLK_DIV - 1));
  assign rise_tick = term & ~mdc_q;
  assign fall_tick = term & mdc_q;
  assign mdc       = mdc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      div_q <= term ? '0 : div_q + DW'(1);
      if (term) mdc_q <= ~mdc_q;
    end
  end

endmodule

// File: rtl/mdio_master_seq.sv
// MDIO master: replays NUM_INIT init frames after reset, then serves runtime
// read/write commands over a valid/ready port.
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_read (or cmd_op/cmd_st45), cmd_phy, cmd_reg, cmd_wdata
//   rsp_valid, rsp_rdata : read completion strobe and held read data
//   init_done, busy      : status
//   mdc, mdio_i, mdio_o, mdio_t : PHY pads (mdio_t=1 releases the line)
// Build option: define MDIO_CLAUSE45_EN for cmd_op[1:0] and cmd_st45 ports.
module mdio_master_seq
  import mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 10,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter int unsigned GAP_LEN      = 64,
  parameter int unsigned NUM_INIT     = 3,
  parameter logic [((NUM_INIT > 0) ? NUM_INIT : 1)*32-1:0] INIT_FRAMES = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
`ifdef MDIO_CLAUSE45_EN
  input  logic [1:0]  cmd_op,
  input  logic        cmd_st45,
`else
  input  logic        cmd_read,
`endif
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        init_done,
  output logic        busy,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t
);

  localparam int unsigned MAX_A   = (PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN;
  localparam int unsigned MAX_LEN = (MAX_A > 32) ? MAX_A : 32;
  localparam int unsigned CW      = $clog2(MAX_LEN + 1);
  localparam int unsigned IW      = (NUM_INIT > 0) ? $clog2(NUM_INIT + 1) : 1;

  mdio_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, last_cnt;
  logic [IW-1:0] idx_q, idx_d;
  logic          arm_q, arm_d, rd_q, rd_d, init_q, init_d, done_q, done_d;
  logic [31:0]   frame_q, frame_d, init_frame, cmd_frame;
  logic          cmd_is_read;
  logic          mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
  logic [14:0]   sh_q, sh_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          rsp_q, rsp_d;
  logic          rise_tick, fall_tick;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .mdc       (mdc),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    init_frame = '0;
    for (int unsigned k = 0; k < NUM_INIT; k++) begin
      if (idx_q == IW'(k)) init_frame = INIT_FRAMES[k*32 +: 32];
    end
  end

  always_comb begin
`ifdef MDIO_CLAUSE45_EN
    cmd_is_read = cmd_op[1];
    cmd_frame   = mdio_frame(cmd_op, cmd_phy, cmd_reg, cmd_wdata);
    if (cmd_st45) cmd_frame[FRM_ST_LSB +: 2] = ST_C45;
`else
    cmd_is_read = cmd_read;
    cmd_frame   = mdio_frame(cmd_read ? OP_READ : OP_WRITE, cmd_phy, cmd_reg, cmd_wdata);
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    arm_d    = arm_q;
    frame_d  = frame_q;
    rd_d     = rd_q;
    init_d   = init_q;
    done_d   = done_q;
    mdio_o_d = mdio_o_q;
    mdio_t_d = mdio_t_q;
    sh_d     = sh_q;
    rdata_d  = rdata_q;
    rsp_d    = 1'b0;
    cmd_ready = (state_q == IDLE) && done_q;

    case (state_q)
      GAP:     last_cnt = CW'(GAP_LEN - 1);
      PRE:     last_cnt = CW'(PREAMBLE_LEN - 1);
      HDR:     last_cnt = CW'(HDR_BITS - 1);
      TA:      last_cnt = CW'(TA_BITS - 1);
      default: last_cnt = CW'(DATA_BITS - 1);
    endcase

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = PRE;
          cnt_d   = '0;
          arm_d   = 1'b1;
          frame_d = cmd_frame;
          rd_d    = cmd_is_read;
          init_d  = 1'b0;
        end
      end
      default: begin
        if (fall_tick) begin
          // A command accepted mid-MDC-cycle waits for the next fall before
          // its first preamble cycle counts.
          if (arm_q) begin
            arm_d = 1'b0;
          end else if (cnt_q == last_cnt) begin
            cnt_d = '0;
            case (state_q)
              GAP: begin
                if (idx_q < IW'(NUM_INIT)) begin
                  state_d = PRE;
                  frame_d = init_frame;
                  rd_d    = init_frame[FRM_OP_MSB];
                  init_d  = 1'b1;
                  idx_d   = idx_q + IW'(1);
                end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end
              end
              PRE:     state_d = HDR;
              HDR:     state_d = TA;
              TA:      state_d = DATA;
              default: state_d = GAP;
            endcase
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase

    // Pad values for the MDC cycle that starts at this fall.
    if (fall_tick && !arm_d) begin
      mdio_t_d = 1'b1;
      mdio_o_d = 1'b0;
      case (state_d)
        PRE: begin
          mdio_t_d = 1'b0;
          mdio_o_d = 1'b1;
        end
        HDR: begin
          mdio_t_d = 1'b0;
          mdio_o_d = frame_d[5'(31 - cnt_d)];
        end
        TA: begin
          if (!rd_d) begin
            mdio_t_d = 1'b0;
            mdio_o_d = frame_d[5'(17 - cnt_d)];
          end
        end
        DATA: begin
          if (!rd_d) begin
            mdio_t_d = 1'b0;
            mdio_o_d = frame_d[5'(15 - cnt_d)];
          end
        end
        default: ;
      endcase
    end

    if (rise_tick && state_q == DATA && rd_q) begin
      sh_d = {sh_q[13:0], mdio_i};
      if (cnt_q == CW'(DATA_BITS - 1) && !init_q) begin
        rdata_d = {sh_q, mdio_i};
        rsp_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= GAP;
      cnt_q    <= '0;
      idx_q    <= '0;
      arm_q    <= 1'b0;
      frame_q  <= '0;
      rd_q     <= 1'b0;
      init_q   <= 1'b0;
      done_q   <= 1'b0;
      mdio_o_q <= 1'b0;
      mdio_t_q <= 1'b1;
      sh_q     <= '0;
      rdata_q  <= '0;
      rsp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      arm_q    <= arm_d;
      frame_q  <= frame_d;
      rd_q     <= rd_d;
      init_q   <= init_d;
      done_q   <= done_d;
      mdio_o_q <= mdio_o_d;
      mdio_t_q <= mdio_t_d;
      sh_q     <= sh_d;
      rdata_q  <= rdata_d;
      rsp_q    <= rsp_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign init_done = done_q;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;

endmodule

// File: tb/tb_mdio_master_seq.sv
// Directed bench for mdio_master_seq with a PHY model and a frame scoreboard.
module tb_mdio_master_seq;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned PRE_LEN  = 32;
  localparam int unsigned GAP_LEN  = 64;
  localparam int unsigned NUM_INIT = 3;
  localparam logic [31:0] INIT0    = 32'h5082_8000;
  localparam logic [31:0] INIT1    = 32'h6087_FFFF;
  localparam logic [31:0] INIT2    = 32'h5092_01E1;
  localparam logic [31:0] RD_MASK  = 32'h0003_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_read = 1'b0;
  logic [4:0]  cmd_phy = '0;
  logic [4:0]  cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, init_done, busy, mdc, mdio_o, mdio_t;
  logic [15:0] rsp_rdata;
  logic        mdio_i = 1'b1;

  typedef struct {
    logic [31:0] frm;
    logic        rd;
    logic        init;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          rel_cnt = 0;
  int          drv_cnt = 0;
  logic [63:0] obs_v = '0;
  logic [63:0] obs_r = '0;
  logic        phy_rd = 1'b0;
  logic [15:0] phy_rdata = 16'h0000;
  int          rsp_cnt = 0;
  int          hs_cnt = 0;

  mdio_master_seq #(
    .CLK_DIV      (CLK_DIV),
    .PREAMBLE_LEN (PRE_LEN),
    .GAP_LEN      (GAP_LEN),
    .NUM_INIT     (NUM_INIT),
    .INIT_FRAMES  ({INIT2, INIT1, INIT0})
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_read  (cmd_read),
    .cmd_phy   (cmd_phy),
    .cmd_reg   (cmd_reg),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .busy      (busy),
    .mdc       (mdc),
    .mdio_i    (mdio_i),
    .mdio_o    (mdio_o),
    .mdio_t    (mdio_t)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] frm, input logic rd, input logic init);
    exp_t e;
    e.frm  = frm;
    e.rd   = rd;
    e.init = init;
    sb.push_back(e);
  endtask

  task automatic push_init();
    push(INIT0, 1'b0, 1'b1);
    push(INIT1, 1'b1, 1'b1);
    push(INIT2, 1'b0, 1'b1);
  endtask

  task automatic frame_check();
    exp_t        e;
    logic [31:0] m;
    check("frame_expected", {63'd0, sb.size() != 0}, 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      m = e.rd ? RD_MASK : 32'h0;
      check("preamble", {obs_v[63:32], obs_r[63:32]}, {32'hFFFF_FFFF, 32'h0});
      check("frame", {obs_r[31:0], obs_v[31:0] & ~m}, {m, e.frm & ~m});
      if (e.init) check("gap_exact", 64'(rel_cnt), 64'(GAP_LEN));
      else        check("gap_min", {63'd0, rel_cnt >= GAP_LEN}, 64'd1);
    end
  endtask

  // PHY side: sample the line on each MDC rise, assemble preamble+frame.
  always @(posedge mdc or negedge reset) begin
    if (!reset) begin
      rel_cnt = 0;
      drv_cnt = 0;
      obs_v   = '0;
      obs_r   = '0;
      phy_rd  = 1'b0;
    end else begin
      #1;
      if (drv_cnt == 0 && mdio_t) begin
        rel_cnt++;
      end else begin
        obs_v = {obs_v[62:0], mdio_o};
        obs_r = {obs_r[62:0], mdio_t};
        drv_cnt++;
        if (drv_cnt == 35) phy_rd = mdio_o;
        if (drv_cnt == 64) begin
          frame_check();
          rel_cnt = 0;
          drv_cnt = 0;
          phy_rd  = 1'b0;
        end
      end
    end
  end

  // PHY drive: turnaround 0 then read data MSB first, changed on MDC fall.
  always @(negedge mdc or negedge reset) begin
    if (!reset) begin
      mdio_i = 1'b1;
    end else begin
      int np;
      np = drv_cnt - 32;
      if (phy_rd && np == 15)                    mdio_i = 1'b0;
      else if (phy_rd && np >= 16 && np <= 31)   mdio_i = phy_rdata[31 - np];
      else                                       mdio_i = 1'b1;
    end
  end

  always @(negedge clk) if (rsp_valid) rsp_cnt++;
  always @(posedge clk) if (cmd_valid && cmd_ready) hs_cnt++;

  task automatic send(input logic rd, input logic [4:0] phy, input logic [4:0] ra,
                      input logic [15:0] wd, input logic [31:0] frm);
    int n = 0;
    @(negedge clk);
    cmd_read  = rd;
    cmd_phy   = phy;
    cmd_reg   = ra;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 4000) begin @(negedge clk); n++; end
    check("send_ready", {63'd0, cmd_ready}, 64'd1);
    if (cmd_ready) push(frm, rd, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin @(negedge clk); n++; end
    check(tag, {62'd0, busy, sb.size() == 0}, 64'b01);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 4000) begin @(negedge clk); n++; end
    @(negedge clk);
    check(tag, {60'd0, init_done, cmd_ready, busy, mdio_t}, 64'b1101);
    check({tag, "_sb"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    int hs0;
    #2 reset = 1'b0;
    #20;
    check("reset_state",
          {mdc, mdio_o, mdio_t, cmd_ready, rsp_valid, init_done, busy, rsp_rdata},
          {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000});
    push_init();
    phy_rdata = 16'hFFFF;
    @(negedge clk);
    reset = 1'b1;
    wait_init("init1");
    check("init_no_rsp", {rsp_rdata, 32'(rsp_cnt)}, {16'h0000, 32'd0});

    send(1'b0, 5'd1, 5'd0, 16'h1140, 32'h5082_1140);
    wait_idle("wr1_idle");

    phy_rdata = 16'h0141;
    send(1'b1, 5'd1, 5'd2, 16'h0000, 32'h6088_0000);
    n = 0;
    while (!rsp_valid && n < 4000) begin @(negedge clk); n++; end
    check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    check("rsp_rdata_0141", 64'(rsp_rdata), 64'h0141);
    @(negedge clk);
    check("rsp_one_clk", {63'd0, rsp_valid}, 64'd0);
    wait_idle("rd1_idle");
    check("rsp_count", 64'(rsp_cnt), 64'd1);

    send(1'b0, 5'h1F, 5'h11, 16'hBEEF, 32'h5FC6_BEEF);
    wait_idle("wr2_idle");
    check("rdata_held", 64'(rsp_rdata), 64'h0141);

    phy_rdata = 16'hA5C3;
    send(1'b1, 5'd3, 5'h1F, 16'h0000, 32'h61FC_0000);
    wait_idle("rd2_idle");
    check("rsp_rdata_a5c3", {16'(rsp_rdata), 32'(rsp_cnt)}, {16'hA5C3, 32'd2});

    // cmd_valid held through a busy frame: one frame per handshake.
    hs0 = hs_cnt;
    @(negedge clk);
    cmd_read = 1'b0; cmd_phy = 5'd2; cmd_reg = 5'd3; cmd_wdata = 16'h1234;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 4000) begin @(negedge clk); n++; end
    push(32'h510E_1234, 1'b0, 1'b0);
    @(negedge clk);
    cmd_phy = 5'd4; cmd_reg = 5'd5; cmd_wdata = 16'h5678;
    check("ready_low_busy", {62'd0, cmd_ready, busy}, 64'b01);
    push(32'h5216_5678, 1'b0, 1'b0);
    n = 0;
    while (!cmd_ready && n < 4000) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle("hold_idle");
    check("handshakes", 64'(hs_cnt - hs0), 64'd2);

    // Reset in the middle of a write's data phase.
    send(1'b0, 5'd1, 5'd0, 16'h1140, 32'h5082_1140);
    n = 0;
    while (drv_cnt < 52 && n < 4000) begin @(negedge clk); n++; end
    #2 reset = 1'b0;
    #1;
    check("reset_mid_data",
          {mdc, mdio_o, mdio_t, cmd_ready, rsp_valid, init_done, busy, rsp_rdata},
          {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000});
    sb.delete();
    push_init();
    phy_rdata = 16'h5A5A;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_init("init2");
    check("reinit_rdata", 64'(rsp_rdata), 64'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
